ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
Parametrised multi-issue instruction fetch unit, successor to the dual-issue fetch stage. It fetches FETCH_W consecutive words per cycle from the icache and applies per-slot BTB predictions. Fetched groups go into a QDEPTH-entry decoupling queue, so decode stalls no longer replay the icache address. A small FSM handles icache misses, and a backend redirect flushes the queue.

Parameters:
FETCH_W, 2, instructions fetched/enqueued/dequeued per cycle (1..4)
QDEPTH, 8, queue entries; power of 2, >= 2*FETCH_W
RESET_PC, 32'h0, fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ic_req  out  1  fetch request this cycle
ic_addr  out  32  address of slot 0 (word aligned)
ic_hit  in  1  combinational: data valid for ic_addr this cycle
ic_data  in  32*FETCH_W  slot i = word at ic_addr+4*i
bp_taken  in  FETCH_W  BTB: slot i predicted taken (combinational on ic_addr)
bp_target  in  32*FETCH_W  BTB: slot i predicted target
redirect  in  1  mispredict/exception redirect from backend
redirect_pc  in  32  correct fetch address
out_valid  out  FETCH_W  bit i set iff queue holds >i entries
out_instr  out  32*FETCH_W  head entries, slot 0 = oldest
out_pc  out  32*FETCH_W  PC of each head entry
out_taken  out  FETCH_W  prediction carried with each entry
out_target  out  32*FETCH_W  predicted target carried with each entry
out_pop  in  clog2(FETCH_W+1)  entries consumed this cycle; must be <= popcount(out_valid)
stat_miss_cycles  out  32  saturating count of cycles spent in MISS

Behaviour:
- Reset (async): pc=RESET_PC, head=tail=count=0, state=RUN, stat_miss_cycles=0. Hence out_valid=0 and ic_req=0 while reset is asserted.
- States: RUN, MISS.
- Fetch enable (fe): !redirect && (QDEPTH - count_reg) >= FETCH_W. Space is judged on the registered count; pops this cycle do not add space.
- ic_req=fe; ic_addr=pc in both states.
- RUN, fe, ic_hit:
  - Let k = lowest slot with bp_taken, else FETCH_W-1.
  - Enqueue slots 0..k with pc+4*i, bp_taken[i], bp_target[i]; slots >k are dropped.
  - Next pc = bp_target[k] if taken, else pc+4*FETCH_W.
- RUN, fe, !ic_hit: go to MISS with no enqueue; pc is held.
- MISS: ic_req stays asserted with the same ic_addr whenever fe. When ic_hit arrives, enqueue as in RUN the same cycle and return to RUN. stat_miss_cycles increments each MISS cycle and saturates at 32'hFFFFFFFF.
- RUN, !fe: pc is held and nothing is enqueued.
- Queue: circular buffer. Each cycle it enqueues 0..FETCH_W entries and dequeues out_pop entries, both in the same cycle. count_next = count + enq - pop. Pointers wrap modulo QDEPTH.
- Outputs are driven from registered head entries with zero additional latency: an entry enqueued in cycle N is visible in cycle N+1.
- Redirect (highest priority), in the cycle asserted:
  - no enqueue; out_pop is ignored.
  - next cycle: head=tail=count=0, pc=redirect_pc, state=RUN; an outstanding miss is abandoned.
  - a redirect asserted while in MISS also abandons the miss.
  - ic_req=0 in the redirect cycle.
- Back-to-back redirects: the last one wins.
- Overflow is impossible by construction.
- Assertions (simulation only): pop > count; count > QDEPTH; ic_addr[1:0] != 0.

Decomposition:
- ifetch_pkg holds: fetch_entry_t struct {instr, pc, taken, target}; fetch_state_e {RUN, MISS}; NOP_INSTR constant for bench fill.
- Sub-module fetch_queue: multi-write/multi-read circular buffer with parameters DEPTH and W. Inputs: enq_cnt, entries, pop_cnt, flush. Outputs: head entries and count.

Test Plan:
- Reset, then always hit, no BTB taken, out_pop=2 each cycle -> ic_addr sequence 0,8,16,24. out_pc pairs (0,4),(8,12) from cycle 2; count steady at 2.
- bp_taken=2'b01 with bp_target[0]=0x100 at pc=0x20 -> only pc 0x20 is enqueued (taken=1, target=0x100); next ic_addr=0x100.
- Miss at 0x40 held for 5 cycles, then hit -> ic_addr=0x40 for 6 cycles and stat_miss_cycles=5. Entries 0x40/0x44 appear the cycle after the hit; next ic_addr=0x48.
- out_pop=0 with continuous hits -> queue fills to 8 after 4 enqueues, ic_req=0 thereafter. out_pop=2 for one cycle -> the fetch that follows is delayed by one cycle.
- Redirect to 0x200 with the queue holding 6 entries and out_pop=2 in the same cycle -> next cycle out_valid=0 and ic_addr=0x200; no entry from before the redirect is ever output.
- Redirect while in MISS -> state returns to RUN, ic_addr=redirect_pc next cycle, stat_miss_cycles stops incrementing. Also: reset asserted mid-miss -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types for the multi-issue fetch unit.
//   fetch_entry_t  - one queued instruction with its PC and BTB prediction
//   fetch_state_e  - fetch FSM states (RUN, MISS)
//   NOP_INSTR      - filler encoding for bench/idle use
package ifetch_pkg;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } fetch_entry_t;

   typedef enum logic {
      RUN  = 1'b0,
      MISS = 1'b1
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer that accepts up to W entries and releases up
// to W entries per cycle.
//   clk, reset  - clock, async active-high reset
//   enq_cnt     - number of leading slots of 'entries' to write this cycle
//   entries     - candidate entries, slot 0 written first
//   pop_cnt     - number of head entries consumed this cycle
//   flush       - empty the queue next cycle (overrides enq/pop)
//   head        - the W oldest entries, slot 0 = oldest
//   count       - registered occupancy
module fetch_queue
   import ifetch_pkg::*;
#(
   parameter  int DEPTH = 8,
   parameter  int W     = 2,
   localparam int CW    = $clog2(W + 1),
   localparam int NW    = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [CW-1:0]          enq_cnt,
   input  fetch_entry_t [W-1:0]   entries,
   input  logic [CW-1:0]          pop_cnt,
   input  logic                   flush,
   output fetch_entry_t [W-1:0]   head,
   output logic [NW-1:0]          count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]            head_q, head_d;
   logic [AW-1:0]            tail_q, tail_d;
   logic [NW-1:0]            count_q, count_d;

   // DEPTH is a power of two, so pointer wrap is plain truncation.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int i = 0; i < W; i++) begin
            if (CW'(i) < enq_cnt) mem_d[tail_q + AW'(i)] = entries[i];
         end
         tail_d  = tail_q + AW'(enq_cnt);
         head_d  = head_q + AW'(pop_cnt);
         count_d = count_q + NW'(enq_cnt) - NW'(pop_cnt);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      for (int i = 0; i < W; i++) head[i] = mem_q[head_q + AW'(i)];
   end

   assign count = count_q;

   a_no_overfill: assert property (@(posedge clk) disable iff (reset)
      count_q <= NW'(DEPTH));
   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      flush || (NW'(pop_cnt) <= count_q));

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: multi-issue instruction fetch with BTB redirection, icache
// miss handling and a decoupling queue toward decode.
//   clk, reset        - clock, async active-high reset
//   ic_req, ic_addr   - icache request and slot-0 address (word aligned)
//   ic_hit, ic_data   - same-cycle icache response, slot i = ic_addr+4*i
//   bp_taken/target   - per-slot BTB prediction for the current group
//   redirect(_pc)     - backend redirect; flushes queue, restarts fetch
//   out_*             - head entries of the queue, slot 0 = oldest
//   out_pop           - entries consumed by decode this cycle
//   stat_miss_cycles  - saturating count of cycles spent in MISS
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter  int          FETCH_W  = 2,
   parameter  int          QDEPTH   = 8,
   parameter  logic [31:0] RESET_PC = 32'h0,
   localparam int          CW       = $clog2(FETCH_W + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  ic_req,
   output logic [31:0]           ic_addr,
   input  logic                  ic_hit,
   input  logic [32*FETCH_W-1:0] ic_data,
   input  logic [FETCH_W-1:0]    bp_taken,
   input  logic [32*FETCH_W-1:0] bp_target,
   input  logic                  redirect,
   input  logic [31:0]           redirect_pc,
   output logic [FETCH_W-1:0]    out_valid,
   output logic [32*FETCH_W-1:0] out_instr,
   output logic [32*FETCH_W-1:0] out_pc,
   output logic [FETCH_W-1:0]    out_taken,
   output logic [32*FETCH_W-1:0] out_target,
   input  logic [CW-1:0]         out_pop,
   output logic [31:0]           stat_miss_cycles
);

   localparam int            NW       = $clog2(QDEPTH + 1);
   localparam int            KW       = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
   localparam logic [NW-1:0] FE_LIMIT = NW'(QDEPTH - FETCH_W);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  stat_q, stat_d;

   logic                        fe;
   logic                        hit_fetch;
   logic                        any_taken;
   logic [KW-1:0]               k;
   logic [31:0]                 k_target;
   logic [CW-1:0]               enq_cnt;
   logic [CW-1:0]               pop_cnt;
   fetch_entry_t [FETCH_W-1:0]  entries;
   fetch_entry_t [FETCH_W-1:0]  head;
   logic [NW-1:0]               q_count;

   // Space is judged on the registered count only, so a pop this cycle
   // never enables a fetch in the same cycle. Reset is folded in so the
   // request line stays low while reset is held.
   assign fe        = !reset && !redirect && (q_count <= FE_LIMIT);
   assign hit_fetch = fe && ic_hit;

   // Lowest taken slot ends the group; scanning downward lets the lowest
   // match overwrite any higher one.
   always_comb begin
      k         = KW'(FETCH_W - 1);
      k_target  = bp_target[32*(FETCH_W-1) +: 32];
      any_taken = 1'b0;
      for (int i = FETCH_W - 1; i >= 0; i--) begin
         if (bp_taken[i]) begin
            k         = KW'(i);
            k_target  = bp_target[32*i +: 32];
            any_taken = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Next state: redirect abandons any outstanding miss
   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN:  if (fe && !ic_hit) state_d = MISS;
            MISS: if (fe && ic_hit)  state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   // FSM outputs: the address is held in both states, so a miss simply
   // re-presents the same request until it hits.
   always_comb begin
      ic_req  = fe;
      ic_addr = pc_q;
      enq_cnt = hit_fetch ? (CW'(k) + CW'(1)) : '0;
      pop_cnt = redirect ? '0 : out_pop;
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect)       pc_d = redirect_pc;
      else if (hit_fetch) pc_d = any_taken ? k_target : pc_q + 32'(4*FETCH_W);
   end

   always_comb begin
      stat_d = stat_q;
      if (state_q == MISS && stat_q != 32'hFFFF_FFFF) stat_d = stat_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         stat_q <= '0;
      end else begin
         pc_q   <= pc_d;
         stat_q <= stat_d;
      end
   end

   always_comb begin
      for (int i = 0; i < FETCH_W; i++) begin
         entries[i].instr  = ic_data[32*i +: 32];
         entries[i].pc     = pc_q + 32'(4*i);
         entries[i].taken  = bp_taken[i];
         entries[i].target = bp_target[32*i +: 32];
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH),
      .W     (FETCH_W)
   ) u_queue (
      .clk     (clk),
      .reset   (reset),
      .enq_cnt (enq_cnt),
      .entries (entries),
      .pop_cnt (pop_cnt),
      .flush   (redirect),
      .head    (head),
      .count   (q_count)
   );

   always_comb begin
      for (int i = 0; i < FETCH_W; i++) begin
         out_valid[i]            = q_count > NW'(i);
         out_instr[32*i +: 32]   = head[i].instr;
         out_pc[32*i +: 32]      = head[i].pc;
         out_taken[i]            = head[i].taken;
         out_target[32*i +: 32]  = head[i].target;
      end
   end

   assign stat_miss_cycles = stat_q;

   a_addr_aligned: assert property (@(posedge clk) disable iff (reset)
      ic_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

   localparam int          FW  = 2;
   localparam int          QD  = 8;
   localparam logic [31:0] RPC = 32'h0;
   localparam int          CW  = $clog2(FW + 1);

   logic               clk = 1'b0;
   logic               reset;
   logic               ic_req;
   logic [31:0]        ic_addr;
   logic               ic_hit;
   logic [32*FW-1:0]   ic_data;
   logic [FW-1:0]      bp_taken;
   logic [32*FW-1:0]   bp_target;
   logic               redirect;
   logic [31:0]        redirect_pc;
   logic [FW-1:0]      out_valid;
   logic [32*FW-1:0]   out_instr;
   logic [32*FW-1:0]   out_pc;
   logic [FW-1:0]      out_taken;
   logic [32*FW-1:0]   out_target;
   logic [CW-1:0]      out_pop;
   logic [31:0]        stat_miss_cycles;

   always #5 clk = ~clk;

   ifetch_queue #(.FETCH_W(FW), .QDEPTH(QD), .RESET_PC(RPC)) dut (
      .clk              (clk),
      .reset            (reset),
      .ic_req           (ic_req),
      .ic_addr          (ic_addr),
      .ic_hit           (ic_hit),
      .ic_data          (ic_data),
      .bp_taken         (bp_taken),
      .bp_target        (bp_target),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .out_valid        (out_valid),
      .out_instr        (out_instr),
      .out_pc           (out_pc),
      .out_taken        (out_taken),
      .out_target       (out_target),
      .out_pop          (out_pop),
      .stat_miss_cycles (stat_miss_cycles)
   );

   // Reference model: a plain FIFO of fetched instructions plus fetch PC,
   // a miss flag and the miss-cycle statistic.
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_miss;
   logic [31:0] m_stat;
   int          total = 0;
   int          bad   = 0;

   function automatic logic [31:0] mkinstr(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_fe();
      return !redirect && ((QD - mq.size()) >= FW);
   endfunction

   task automatic check_outputs();
      logic [FW-1:0] vld;
      chk("ic_req", ic_req, model_fe());
      chk("ic_addr", ic_addr, m_pc);
      for (int i = 0; i < FW; i++) vld[i] = (mq.size() > i);
      chk("out_valid", out_valid, vld);
      chk("stat", stat_miss_cycles, m_stat);
      for (int i = 0; i < FW; i++) begin
         if (i < mq.size()) begin
            chk("out_instr",  out_instr[32*i +: 32],  mq[i].instr);
            chk("out_pc",     out_pc[32*i +: 32],     mq[i].pc);
            chk("out_taken",  out_taken[i],           mq[i].taken);
            chk("out_target", out_target[32*i +: 32], mq[i].target);
         end
      end
   endtask

   task automatic model_update();
      bit   fe;
      int   k;
      ent_t e;
      fe = model_fe();
      if (m_miss && m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 1;
      if (redirect) begin
         mq.delete();
         m_pc   = redirect_pc;
         m_miss = 0;
      end else begin
         for (int i = 0; i < int'(out_pop); i++) e = mq.pop_front();
         if (fe) begin
            if (ic_hit) begin
               k = 0;
               while (k < FW - 1 && !bp_taken[k]) k++;
               for (int i = 0; i <= k; i++) begin
                  e.pc     = m_pc + 4*i;
                  e.instr  = mkinstr(e.pc);
                  e.taken  = bp_taken[i];
                  e.target = bp_target[32*i +: 32];
                  mq.push_back(e);
               end
               m_pc   = bp_taken[k] ? bp_target[32*k +: 32] : m_pc + 4*FW;
               m_miss = 0;
            end else begin
               m_miss = 1;
            end
         end
      end
   endtask

   // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
   task automatic cyc(input bit rd, input logic [31:0] rpc, input bit hit,
                      input logic [FW-1:0] tk, input logic [32*FW-1:0] tg,
                      input int pop);
      int p;
      p = pop;
      if (p > mq.size()) p = mq.size();
      if (p > FW) p = FW;
      redirect    = rd;
      redirect_pc = rpc;
      ic_hit      = hit;
      bp_taken    = tk;
      bp_target   = tg;
      out_pop     = CW'(p);
      for (int i = 0; i < FW; i++) ic_data[32*i +: 32] = mkinstr(m_pc + 32'(4*i));
      @(negedge clk);
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = RPC;
      m_miss = 0;
      m_stat = '0;
   endtask

   initial begin
      logic [FW-1:0]    tk;
      logic [32*FW-1:0] tg;
      reset = 1'b1; redirect = 0; redirect_pc = '0; ic_hit = 0;
      bp_taken = '0; bp_target = '0; out_pop = '0; ic_data = '0;
      model_reset();
      #12;
      chk("rst_ic_req", ic_req, 1'b0);
      chk("rst_valid", out_valid, '0);
      chk("rst_stat", stat_miss_cycles, 32'd0);
      chk("rst_addr", ic_addr, RPC);
      @(posedge clk); #1;
      reset = 1'b0;

      // Sequential hits, no prediction, steady pop of 2
      for (int i = 0; i < 4; i++) begin
         chk("seq_addr", ic_addr, 32'(8*i));
         cyc(0, '0, 1, '0, '0, 2);
      end

      // Slot 0 predicted taken: slot 1 dropped, fetch moves to target
      cyc(0, '0, 1, 2'b01, {32'h0, 32'h100}, 2);
      chk("tk_addr", ic_addr, 32'h100);
      chk("tk_valid", out_valid, 2'b01);
      chk("tk_pc", out_pc[31:0], 32'h20);
      chk("tk_taken", out_taken[0], 1'b1);
      chk("tk_target", out_target[31:0], 32'h100);

      // Slot 1 taken to 0x40, then a 5-cycle miss there
      cyc(0, '0, 1, 2'b10, {32'h40, 32'h0}, 2);
      for (int i = 0; i < 5; i++) cyc(0, '0, 0, '0, '0, 2);
      cyc(0, '0, 1, '0, '0, 2);
      chk("miss_stat", stat_miss_cycles, 32'd5);
      chk("miss_next", ic_addr, 32'h48);
      chk("miss_pcs", out_pc, {32'h44, 32'h40});

      // No pops: queue fills and fetch stops
      for (int i = 0; i < 6; i++) cyc(0, '0, 1, '0, '0, 0);
      chk("full_noreq", ic_req, 1'b0);
      chk("full_valid", out_valid, 2'b11);
      cyc(0, '0, 1, '0, '0, 2);

      // Redirect with 6 queued and a pop in the same cycle
      cyc(1, 32'h200, 1, '0, '0, 2);
      chk("redir_valid", out_valid, '0);
      chk("redir_addr", ic_addr, 32'h200);
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, '0, '0, 2);

      // Redirect while missing
      for (int i = 0; i < 3; i++) cyc(0, '0, 0, '0, '0, 2);
      cyc(1, 32'h300, 0, '0, '0, 0);
      chk("mredir_addr", ic_addr, 32'h300);
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, '0, '0, 1);

      // Reset asserted mid-miss
      cyc(0, '0, 0, '0, '0, 2);
      cyc(0, '0, 0, '0, '0, 2);
      reset = 1'b1;
      #1;
      chk("mrst_ic_req", ic_req, 1'b0);
      chk("mrst_valid", out_valid, '0);
      chk("mrst_stat", stat_miss_cycles, 32'd0);
      chk("mrst_addr", ic_addr, RPC);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < FW; i++) begin
            tk[i]            = ($urandom_range(0, 3) == 0);
            tg[32*i +: 32]   = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
         end
         cyc(($urandom_range(0, 19) == 0), 32'($urandom_range(0, 4095)) & 32'hFFFF_FFFC,
             ($urandom_range(0, 3) != 0), tk, tg, $urandom_range(0, FW));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
